// File: rtl/cfg_sched_pkg.sv
// Shared definitions for the configuration commit scheduler: FSM states,
// bridge address map and counter sizing.
package cfg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SETTLE = 2'd3
    } sched_state_e;

    localparam int CNT_W = 16;

    // Reset-class addresses: writing any of them (re)starts the core reset hold.
    localparam logic [31:0] ADDR_RESET_CMD = 32'hF000_0000;
    localparam logic [31:0] ADDR_DIP       = 32'hF100_0000;
    localparam logic [31:0] ADDR_EXT       = 32'hF400_0000;
    // Modifiers take effect immediately and never touch the reset sequence.
    localparam logic [31:0] ADDR_MOD       = 32'hF200_0000;
    // Read-only status word.
    localparam logic [31:0] ADDR_STATUS    = 32'hF000_0004;

    function automatic logic is_rc_addr(input logic [31:0] addr);
        return (addr == ADDR_RESET_CMD) || (addr == ADDR_DIP) || (addr == ADDR_EXT);
    endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down counter with zero flag. Load has priority over decrement and
// the count saturates at zero instead of wrapping.
module sched_down_counter #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise decrement while above zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register; reset reloads the power-on value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cfg_commit_sched.sv
// Configuration commit scheduler: stages DIP/extra-DIP writes from the APF
// bridge, holds the core in reset, then commits the staged values atomically
// and releases the core after a short settle period.
module cfg_commit_sched
    import cfg_sched_pkg::*;
#(
    parameter int HOLD_CYCLES   = 8000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic [31:0] dip_cfg,
    output logic [31:0] ext_cfg,
    output logic [31:0] mod_cfg,
    output logic        core_reset,
    output logic        commit_pulse,
    output logic        busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    sched_state_e state_q, state_d;

    logic [31:0] dip_stg_q, dip_stg_d;
    logic [31:0] ext_stg_q, ext_stg_d;
    logic [31:0] dip_q, dip_d;
    logic [31:0] ext_q, ext_d;
    logic [31:0] mod_q, mod_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        commit_q, commit_d;

    logic             rc_wr;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             busy_w;

    assign rc_wr  = bridge_wr && is_rc_addr(bridge_addr);
    assign busy_w = (state_q != ST_IDLE);

    sched_down_counter #(
        .WIDTH     (CNT_W),
        .RESET_VAL (HOLD_LOAD)
    ) u_counter (
        .clk_i      (clk_74a),
        .rst_ni     (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Sequencer: any reset-class write restarts HOLD; otherwise walk
    // HOLD -> COMMIT -> SETTLE -> IDLE driven by the counter.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = HOLD_LOAD;
        cnt_dec      = 1'b0;
        if (rc_wr) begin
            state_d  = ST_HOLD;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_zero) state_d = ST_COMMIT;
                    else          cnt_dec = 1'b1;
                end
                ST_COMMIT: begin
                    state_d      = ST_SETTLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (cnt_zero) state_d = ST_IDLE;
                    else          cnt_dec = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Staging, commit copy, modifiers and bridge read mux. Reads sample the
    // current registers so a same-cycle write is seen only by later reads.
    always_comb begin
        dip_stg_d = dip_stg_q;
        ext_stg_d = ext_stg_q;
        mod_d     = mod_q;
        rd_data_d = rd_data_q;
        if (bridge_wr && (bridge_addr == ADDR_DIP)) dip_stg_d = bridge_wr_data;
        if (bridge_wr && (bridge_addr == ADDR_EXT)) ext_stg_d = bridge_wr_data;
        if (bridge_wr && (bridge_addr == ADDR_MOD)) mod_d     = bridge_wr_data;

        // COMMIT is only ever entered from HOLD and lasts one cycle, so this
        // fires exactly once per commit, on the edge the pulse rises.
        commit_d = (state_d == ST_COMMIT);
        dip_d    = commit_d ? dip_stg_q : dip_q;
        ext_d    = commit_d ? ext_stg_q : ext_q;

        if (bridge_rd) begin
            case (bridge_addr)
                ADDR_DIP:    rd_data_d = dip_stg_q;
                ADDR_EXT:    rd_data_d = ext_stg_q;
                ADDR_MOD:    rd_data_d = mod_q;
                ADDR_STATUS: rd_data_d = {29'h0, busy_w, state_q};
                default:     rd_data_d = 32'h0;
            endcase
        end
    end

    // State and data registers; reset restarts the power-on sequence in HOLD.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state_q   <= ST_HOLD;
            dip_stg_q <= 32'h0;
            ext_stg_q <= 32'h0;
            dip_q     <= 32'h0;
            ext_q     <= 32'h0;
            mod_q     <= 32'h0;
            rd_data_q <= 32'h0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dip_stg_q <= dip_stg_d;
            ext_stg_q <= ext_stg_d;
            dip_q     <= dip_d;
            ext_q     <= ext_d;
            mod_q     <= mod_d;
            rd_data_q <= rd_data_d;
            commit_q  <= commit_d;
        end
    end

    assign bridge_rd_data = rd_data_q;
    assign dip_cfg        = dip_q;
    assign ext_cfg        = ext_q;
    assign mod_cfg        = mod_q;
    assign core_reset     = busy_w;
    assign busy           = busy_w;
    assign commit_pulse   = commit_q;

endmodule

// File: tb/tb_cfg_commit_sched.sv
// Scoreboard bench for cfg_commit_sched: a driver issues directed then random
// bridge traffic and pushes expected outputs from a timeline model; a monitor
// on the falling edge pops and compares.
module tb_cfg_commit_sched;

    localparam int H = 8;
    localparam int S = 4;
    localparam int SEQ_LEN = H + 1 + S;

    localparam logic [31:0] A_RC   = 32'hF000_0000;
    localparam logic [31:0] A_DIP  = 32'hF100_0000;
    localparam logic [31:0] A_EXT  = 32'hF400_0000;
    localparam logic [31:0] A_MOD  = 32'hF200_0000;
    localparam logic [31:0] A_STAT = 32'hF000_0004;
    localparam logic [31:0] A_UNM  = 32'hF900_0000;

    // Starts high so the first falling edge lands inside the first driven cycle.
    logic clk_74a = 1'b1;
    always #5 clk_74a = ~clk_74a;

    logic        reset_n;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    logic [31:0] dip_cfg;
    logic [31:0] ext_cfg;
    logic [31:0] mod_cfg;
    logic        core_reset;
    logic        commit_pulse;
    logic        busy;

    cfg_commit_sched #(
        .HOLD_CYCLES   (H),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk_74a        (clk_74a),
        .reset_n        (reset_n),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd      (bridge_rd),
        .bridge_rd_data (bridge_rd_data),
        .dip_cfg        (dip_cfg),
        .ext_cfg        (ext_cfg),
        .mod_cfg        (mod_cfg),
        .core_reset     (core_reset),
        .commit_pulse   (commit_pulse),
        .busy           (busy)
    );

    typedef struct {
        bit          chk;
        logic        core_reset;
        logic        commit;
        logic [31:0] dip;
        logic [31:0] ext;
        logic [31:0] mod;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit stim_active = 1'b1;

    // Reference model: position in the reset timeline counted from the most
    // recent HOLD start, plus the architectural registers.
    int          m_since;
    bit          m_valid = 1'b0;
    logic [31:0] m_dip_stg, m_ext_stg, m_dip, m_ext, m_mod;

    function automatic int phase_of(input int s);
        if (s < H)        return 1;
        else if (s == H)  return 2;
        else if (s < SEQ_LEN) return 3;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, record expectations for it, then advance the model.
    task automatic step(input logic rst_n, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rd);
        exp_t e;
        int   ph;
        bit   rc;
        reset_n        = rst_n;
        bridge_wr      = wr;
        bridge_addr    = addr;
        bridge_wr_data = wdata;
        bridge_rd      = rd;

        ph           = phase_of(m_since);
        e.chk        = m_valid;
        e.core_reset = (ph != 0);
        e.commit     = (ph == 2);
        e.dip        = m_dip;
        e.ext        = m_ext;
        e.mod        = m_mod;
        exp_q.push_back(e);

        if (!rst_n) begin
            rd_q.push_back(32'h0);
        end else if (rd) begin
            if (addr == A_DIP)       rd_q.push_back(m_dip_stg);
            else if (addr == A_EXT)  rd_q.push_back(m_ext_stg);
            else if (addr == A_MOD)  rd_q.push_back(m_mod);
            else if (addr == A_STAT) rd_q.push_back({29'h0, (ph != 0), 2'(ph)});
            else                     rd_q.push_back(32'h0);
        end

        if (!rst_n) begin
            m_valid   = 1'b1;
            m_since   = 0;
            m_dip_stg = 0; m_ext_stg = 0;
            m_dip     = 0; m_ext     = 0; m_mod = 0;
        end else begin
            rc = wr && (addr == A_RC || addr == A_DIP || addr == A_EXT);
            if (wr && addr == A_MOD) m_mod = wdata;
            if (rc) begin
                if (addr == A_DIP) m_dip_stg = wdata;
                if (addr == A_EXT) m_ext_stg = wdata;
                m_since = 0;
            end else if (m_since < SEQ_LEN) begin
                m_since++;
                if (m_since == H) begin
                    m_dip = m_dip_stg;
                    m_ext = m_ext_stg;
                end
            end
        end

        @(posedge clk_74a);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: one per-cycle expectation each falling edge; read data is
    // checked the cycle after a read (or reset), otherwise it must hold.
    initial begin
        exp_t        e;
        bit          pend = 1'b0;
        bit          held_ok = 1'b0;
        logic [31:0] held = 32'h0;
        forever begin
            @(negedge clk_74a);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("core_reset",   32'(core_reset),   32'(e.core_reset));
                    check("busy",         32'(busy),         32'(e.core_reset));
                    check("commit_pulse", 32'(commit_pulse), 32'(e.commit));
                    check("dip_cfg",      dip_cfg,           e.dip);
                    check("ext_cfg",      ext_cfg,           e.ext);
                    check("mod_cfg",      mod_cfg,           e.mod);
                end
            end else if (stim_active) begin
                check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            end
            if (pend) begin
                if (rd_q.size() > 0) begin
                    held = rd_q.pop_front();
                    held_ok = 1'b1;
                    check("rd_data", bridge_rd_data, held);
                end else begin
                    check("rd_queue_underflow", 32'(rd_q.size()), 32'd1);
                end
            end else if (held_ok) begin
                check("rd_data_hold", bridge_rd_data, held);
            end
            pend = stim_active && (!reset_n || bridge_rd);
        end
    end

    initial begin
        logic [31:0] addr_tab [7];
        logic [31:0] a;
        logic        wr, rd, rst;
        addr_tab = '{A_RC, A_DIP, A_EXT, A_MOD, A_STAT, A_UNM, 32'h0};

        // Power-up: reset low 4 cycles, then the full sequence runs.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(SEQ_LEN + 4);

        // Single DIP write from IDLE.
        step(1'b1, 1'b1, A_DIP, 32'h0000_00A5, 1'b0);
        idle(SEQ_LEN + 3);

        // Retrigger five cycles into HOLD with an extra-DIP write.
        step(1'b1, 1'b1, A_DIP, 32'h0000_00B6, 1'b0);
        idle(4);
        step(1'b1, 1'b1, A_EXT, 32'h1234_5678, 1'b0);
        idle(SEQ_LEN + 3);

        // Write landing in SETTLE forces a second commit.
        step(1'b1, 1'b1, A_DIP, 32'h0000_0007, 1'b0);
        idle(H + 1);
        step(1'b1, 1'b1, A_DIP, 32'h0000_0001, 1'b0);
        idle(SEQ_LEN + 3);

        // Modifier write during HOLD.
        step(1'b1, 1'b1, A_RC, 32'h0, 1'b0);
        idle(2);
        step(1'b1, 1'b1, A_MOD, 32'h0000_00FF, 1'b0);
        idle(SEQ_LEN + 3);

        // Same-cycle read/write, follow-up read, unmapped read, status read.
        step(1'b1, 1'b1, A_DIP, 32'h0000_0011, 1'b0);
        idle(SEQ_LEN + 2);
        step(1'b1, 1'b1, A_DIP, 32'h0000_0022, 1'b1);
        step(1'b1, 1'b0, A_DIP, 32'h0, 1'b1);
        step(1'b1, 1'b0, A_UNM, 32'h0, 1'b1);
        step(1'b1, 1'b0, A_STAT, 32'h0, 1'b1);
        idle(3);

        // Mid-sequence reset drops staged values.
        step(1'b1, 1'b1, A_EXT, 32'hDEAD_BEEF, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(SEQ_LEN + 3);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            a   = addr_tab[$urandom_range(0, 6)];
            if (a == 32'h0) a = $urandom;
            wr  = ($urandom_range(0, 99) < 12);
            rd  = ($urandom_range(0, 3) == 0) && (a != A_RC) && (a != A_MOD);
            step(rst, wr, a, $urandom, rd);
        end
        idle(SEQ_LEN + 4);

        stim_active = 1'b0;
        @(negedge clk_74a);
        #1;
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
